udma_i2c_rx_packer: RTL and testbench

- Sits directly downstream of the I2C uDMA RX path, in the sys_clk domain.
- Consumes the 8-bit RX byte stream (data/valid/ready) leaving the RX dual-clock FIFO and packs bytes little-endian into 32-bit words for the uDMA RX channel.
- Drives a datasize code per beat.
- On an end-of-transfer pulse it flushes any partial word as halfword/byte beats, so no received data is stranded.

---
 rtl/udma_i2c_rx_packer_if.sv | 37 +++
 rtl/udma_i2c_rx_packer.sv | 144 ++++++++++++++
 tb/tb_udma_i2c_rx_packer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_i2c_rx_packer_if.sv
// Byte-in / beat-out stream bundle for the I2C uDMA RX packer.
// The slave modport is the packer's view; the master modport is the view of whatever surrounds it.
interface udma_i2c_rx_packer_if #(
    parameter int BYTE_W = 8,
    parameter int WORD_W = 32
);
    logic [BYTE_W-1:0] data_rx_i;
    logic              data_rx_valid_i;
    logic              data_rx_ready_o;
    logic              eot_i;
    logic [WORD_W-1:0] data_o;
    logic [1:0]        data_datasize_o;
    logic              data_valid_o;
    logic              data_ready_i;

    modport slave (
        input  data_rx_i,
        input  data_rx_valid_i,
        input  eot_i,
        input  data_ready_i,
        output data_rx_ready_o,
        output data_o,
        output data_datasize_o,
        output data_valid_o
    );

    modport master (
        output data_rx_i,
        output data_rx_valid_i,
        output eot_i,
        output data_ready_i,
        input  data_rx_ready_o,
        input  data_o,
        input  data_datasize_o,
        input  data_valid_o
    );
endinterface

// File: rtl/udma_i2c_rx_packer.sv
// Packs the I2C RX byte stream little-endian into 32-bit uDMA beats with a per-beat datasize,
// flushing any partial word as halfword/byte beats on end-of-transfer.
module udma_i2c_rx_packer #(
    parameter int BYTE_W     = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      cfg_pack_en_i,
    udma_i2c_rx_packer_if.slave       bus,
    output logic                      busy_o
);
    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int ACC_W  = WORD_W - BYTE_W;
    localparam int HALF_W = 2 * BYTE_W;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        cnt_q,        cnt_d;
    logic [ACC_W-1:0]  acc_q,        acc_d;
    logic              flush_pend_q, flush_pend_d;
    logic              mode_q,       mode_d;
    logic [WORD_W-1:0] data_q,       data_d;
    logic [1:0]        size_q,       size_d;
    logic              valid_q,      valid_d;

    logic out_free;
    logic rx_ready;
    logic rx_fire;

    function automatic logic [WORD_W-1:0] byte_beat(input logic [BYTE_W-1:0] b);
        return {{(WORD_W-BYTE_W){1'b0}}, b};
    endfunction

    function automatic logic [WORD_W-1:0] half_beat(input logic [ACC_W-1:0] a);
        return {{(WORD_W-HALF_W){1'b0}}, a[HALF_W-1:0]};
    endfunction

    always_comb begin
        out_free = ~valid_q | bus.data_ready_i;
        rx_ready = ~clr_i & ~flush_pend_q & out_free;
        rx_fire  = bus.data_rx_valid_i & rx_ready;
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        size_d       = size_q;
        valid_d      = valid_q & ~bus.data_ready_i;
        // The mode may only change on a word boundary with nothing left to flush.
        mode_d       = ((cnt_q == 2'd0) && !flush_pend_q) ? cfg_pack_en_i : mode_q;

        if (clr_i) begin
            cnt_d        = 2'd0;
            acc_d        = '0;
            flush_pend_d = 1'b0;
            data_d       = '0;
            size_d       = SZ_BYTE;
            valid_d      = 1'b0;
        end else begin
            if (rx_fire) begin
                if (!mode_q) begin
                    data_d  = byte_beat(bus.data_rx_i);
                    size_d  = SZ_BYTE;
                    valid_d = 1'b1;
                end else if (cnt_q == 2'd3) begin
                    data_d  = {bus.data_rx_i, acc_q};
                    size_d  = SZ_WORD;
                    valid_d = 1'b1;
                    cnt_d   = 2'd0;
                end else begin
                    acc_d[int'(cnt_q)*BYTE_W +: BYTE_W] = bus.data_rx_i;
                    cnt_d = cnt_q + 2'd1;
                end
            end

            if (flush_pend_q) begin
                // No byte can be accepted while a flush is pending, so cnt_q is stable here.
                if (out_free) begin
                    case (cnt_q)
                        2'd1: begin
                            data_d       = byte_beat(acc_q[BYTE_W-1:0]);
                            size_d       = SZ_BYTE;
                            valid_d      = 1'b1;
                            cnt_d        = 2'd0;
                            flush_pend_d = 1'b0;
                        end
                        2'd2: begin
                            data_d       = half_beat(acc_q);
                            size_d       = SZ_HALF;
                            valid_d      = 1'b1;
                            cnt_d        = 2'd0;
                            flush_pend_d = 1'b0;
                        end
                        2'd3: begin
                            data_d  = half_beat(acc_q);
                            size_d  = SZ_HALF;
                            valid_d = 1'b1;
                            acc_d   = acc_q >> HALF_W;
                            cnt_d   = 2'd1;
                        end
                        default: begin
                            flush_pend_d = 1'b0;
                        end
                    endcase
                end
            end else if (bus.eot_i && mode_q && (cnt_d != 2'd0)) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= 2'd0;
            acc_q        <= '0;
            flush_pend_q <= 1'b0;
            mode_q       <= 1'b0;
            data_q       <= '0;
            size_q       <= SZ_BYTE;
            valid_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            flush_pend_q <= flush_pend_d;
            mode_q       <= mode_d;
            data_q       <= data_d;
            size_q       <= size_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.data_rx_ready_o = rx_ready;
    assign bus.data_o          = data_q;
    assign bus.data_datasize_o = size_q;
    assign bus.data_valid_o    = valid_q;
    assign busy_o              = (cnt_q != 2'd0) | flush_pend_q | valid_q;

endmodule

// File: tb/tb_udma_i2c_rx_packer.sv
// Randomised and directed bench for udma_i2c_rx_packer against a queue-based beat model.
module tb_udma_i2c_rx_packer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic cfg = 1'b0;
    logic busy;

    udma_i2c_rx_packer_if bus ();

    always #5 clk = ~clk;

    udma_i2c_rx_packer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clr_i         (clr),
        .cfg_pack_en_i (cfg),
        .bus           (bus),
        .busy_o        (busy)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  sz;
        bit          fl;
    } beat_t;

    beat_t      expq[$];
    beat_t      obs[$];
    logic [7:0] hold[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic [1:0] sz, input bit fl);
        beat_t b;
        b.d  = d;
        b.sz = sz;
        b.fl = fl;
        return b;
    endfunction

    // Model: checks the current cycle, then applies what the coming edge will do.
    always @(negedge clk) begin
        int  nfl;
        bit  fp;
        bit  fire;
        if (rst) begin
            expq.delete();
            hold.delete();
        end else begin
            nfl = 0;
            foreach (expq[i]) if (expq[i].fl) nfl++;
            if (bus.data_valid_o && expq.size() > 0 && expq[0].fl) nfl--;
            fp = (nfl > 0);
            chk("rx_ready", {31'b0, bus.data_rx_ready_o},
                {31'b0, !clr && !fp && (!bus.data_valid_o || bus.data_ready_i)});
            chk("busy", {31'b0, busy}, {31'b0, (hold.size() != 0) || (expq.size() != 0)});
            if (bus.data_valid_o) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", bus.data_o, 32'hxxxx_xxxx);
                end else begin
                    chk("beat_data", bus.data_o, expq[0].d);
                    chk("beat_size", {30'b0, bus.data_datasize_o}, {30'b0, expq[0].sz});
                end
            end

            fire = bus.data_rx_valid_i && bus.data_rx_ready_o;
            if (bus.data_valid_o && bus.data_ready_i) begin
                obs.push_back(mk(bus.data_o, bus.data_datasize_o, 1'b0));
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (clr) begin
                expq.delete();
                hold.delete();
            end else begin
                if (fire) begin
                    if (!cfg) begin
                        expq.push_back(mk({24'h0, bus.data_rx_i}, 2'b00, 1'b0));
                    end else begin
                        hold.push_back(bus.data_rx_i);
                        if (hold.size() == 4) begin
                            expq.push_back(mk({hold[3], hold[2], hold[1], hold[0]}, 2'b10, 1'b0));
                            hold.delete();
                        end
                    end
                end
                if (cfg && bus.eot_i && hold.size() != 0 && !fp) begin
                    if (hold.size() == 1) begin
                        expq.push_back(mk({24'h0, hold[0]}, 2'b00, 1'b1));
                    end else begin
                        expq.push_back(mk({16'h0, hold[1], hold[0]}, 2'b01, 1'b1));
                        if (hold.size() == 3) expq.push_back(mk({24'h0, hold[2]}, 2'b00, 1'b1));
                    end
                    hold.delete();
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        bus.data_rx_i       = b;
        bus.data_rx_valid_i = 1'b1;
        bus.eot_i           = e;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = bus.data_rx_ready_o;
            @(posedge clk);
            #1;
            t++;
        end
        bus.eot_i = 1'b0;
        if (!acc) chk("send_timeout", 32'(t), 32'd0);
    endtask

    task automatic stop_in();
        bus.data_rx_valid_i = 1'b0;
        bus.eot_i           = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || expq.size() != 0) && t < 300) begin
            cycles(1);
            t++;
        end
        chk("idle_reached", {31'b0, t < 300}, 32'd1);
        cycles(1);
    endtask

    task automatic set_mode(input logic m);
        stop_in();
        clr = 1'b0;
        bus.data_ready_i = 1'b1;
        bus.eot_i = 1'b1;
        cycles(1);
        bus.eot_i = 1'b0;
        wait_idle();
        cfg = m;
        cycles(3);
    endtask

    initial begin
        bus.data_rx_i       = 8'h00;
        bus.data_rx_valid_i = 1'b0;
        bus.eot_i           = 1'b0;
        bus.data_ready_i    = 1'b1;

        #1 rst = 1'b1;
        #1;
        chk("rst_data", bus.data_o, 32'h0);
        chk("rst_size", {30'b0, bus.data_datasize_o}, 32'h0);
        chk("rst_valid", {31'b0, bus.data_valid_o}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycles(1);

        // Full word
        set_mode(1'b1);
        obs.delete();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        stop_in();
        wait_idle();
        chk("t1_count", 32'(obs.size()), 32'd1);
        if (obs.size() >= 1) begin
            chk("t1_data", obs[0].d, 32'h4433_2211);
            chk("t1_size", {30'b0, obs[0].sz}, 32'd2);
        end
        chk("t1_busy", {31'b0, busy}, 32'd0);

        // Three bytes then eot: halfword then byte
        obs.delete();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        stop_in();
        cycles(2);
        bus.eot_i = 1'b1;
        cycles(1);
        bus.eot_i = 1'b0;
        wait_idle();
        chk("t2_count", 32'(obs.size()), 32'd2);
        if (obs.size() >= 2) begin
            chk("t2_data0", obs[0].d, 32'h0000_BBAA);
            chk("t2_size0", {30'b0, obs[0].sz}, 32'd1);
            chk("t2_data1", obs[1].d, 32'h0000_00CC);
            chk("t2_size1", {30'b0, obs[1].sz}, 32'd0);
        end

        // eot together with the word-completing byte
        obs.delete();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        stop_in();
        wait_idle();
        chk("t3_count", 32'(obs.size()), 32'd1);
        if (obs.size() >= 1) begin
            chk("t3_data", obs[0].d, 32'h0403_0201);
            chk("t3_size", {30'b0, obs[0].sz}, 32'd2);
        end

        // Pass-through with downstream stall
        set_mode(1'b0);
        obs.delete();
        bus.data_ready_i = 1'b0;
        send_byte(8'h5A, 1'b0);
        bus.data_rx_i = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_data", bus.data_o, 32'h0000_005A);
            chk("t4_hold_valid", {31'b0, bus.data_valid_o}, 32'd1);
            chk("t4_rx_blocked", {31'b0, bus.data_rx_ready_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.data_ready_i = 1'b1;
        send_byte(8'hA5, 1'b0);
        stop_in();
        wait_idle();
        chk("t4_count", 32'(obs.size()), 32'd2);
        if (obs.size() >= 2) begin
            chk("t4_data0", obs[0].d, 32'h0000_005A);
            chk("t4_data1", obs[1].d, 32'h0000_00A5);
            chk("t4_size1", {30'b0, obs[1].sz}, 32'd0);
        end

        // Clear discards a partial word
        set_mode(1'b1);
        obs.delete();
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        stop_in();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        stop_in();
        wait_idle();
        chk("t5_count", 32'(obs.size()), 32'd1);
        if (obs.size() >= 1) chk("t5_data", obs[0].d, 32'h0403_0201);

        // Asynchronous reset mid-stream
        obs.delete();
        send_byte(8'h77, 1'b0);
        stop_in();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_data", bus.data_o, 32'h0);
        chk("t6_rst_valid", {31'b0, bus.data_valid_o}, 32'h0);
        chk("t6_rst_size", {30'b0, bus.data_datasize_o}, 32'h0);
        chk("t6_rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        cycles(3);
        obs.delete();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        stop_in();
        wait_idle();
        chk("t6_count", 32'(obs.size()), 32'd1);
        if (obs.size() >= 1) chk("t6_data", obs[0].d, 32'h0403_0201);

        // Randomised traffic, alternating modes
        for (int chunk = 0; chunk < 6; chunk++) begin
            set_mode(chunk[0] ? 1'b0 : 1'b1);
            for (int c = 0; c < 400; c++) begin
                bus.data_rx_valid_i = ($urandom_range(3) != 0);
                bus.data_rx_i       = 8'($urandom);
                bus.eot_i           = ($urandom_range(15) == 0);
                bus.data_ready_i    = ($urandom_range(3) != 0);
                clr                 = ($urandom_range(49) == 0);
                cycles(1);
            end
        end
        set_mode(1'b1);
        chk("final_queue_empty", 32'(expq.size()), 32'd0);
        chk("final_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
